// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control decoder with load-use stall, flush, hold,
// illegal-opcode flag and saturating bubble counter.
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   opcode       ID-stage opcode
//   id_rs/id_rt  ID-stage register specifiers
//   hold         freeze all state
//   flush        squash ID/EX and EX/MEM (branch taken)
//   ex_ctrl      ID/EX  {RegDst, ALUOp[1:0], ALUSrc}
//   mem_ctrl     EX/MEM {Branch, MemRead, MemWrite}
//   wb_ctrl      MEM/WB {RegWrite, MemtoReg}
//   hazard_stall combinational load-use stall request
//   illegal_op   one-cycle pulse aligned with ex_ctrl of an unknown opcode
//   bubble_cnt   saturating count of inserted bubbles
module ctrl_pipe #(
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int CNT_W    = 16,
    parameter bit EN_ADDI  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                hold,
    input  logic                flush,
    output logic [3:0]          ex_ctrl,
    output logic [2:0]          mem_ctrl,
    output logic [1:0]          wb_ctrl,
    output logic                hazard_stall,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    bubble_cnt
);
    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'('b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'('b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'('b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'('b000100);
    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'('b100000);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'('b001000);

    logic [3:0]       dec_ex;
    logic [2:0]       dec_m;
    logic [1:0]       dec_wb;
    logic             dec_ill;
    logic             use_rt;
    logic [3:0]       idex_ex;
    logic [2:0]       idex_m;
    logic [1:0]       idex_wb;
    logic [REG_W-1:0] idex_rt;
    logic [2:0]       exmem_m;
    logic [1:0]       exmem_wb;
    logic [1:0]       memwb_wb;
    logic             bubble;

    always_comb begin
        dec_ex  = 4'b0000;
        dec_m   = 3'b000;
        dec_wb  = 2'b00;
        dec_ill = 1'b0;
        use_rt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin dec_ex = 4'b1100; dec_wb = 2'b10; use_rt = 1'b1; end
            OP_LW:    begin dec_ex = 4'b0001; dec_m = 3'b010; dec_wb = 2'b11; end
            OP_SW:    begin dec_ex = 4'b0001; dec_m = 3'b001; use_rt = 1'b1; end
            OP_BEQ:   begin dec_ex = 4'b0010; dec_m = 3'b100; use_rt = 1'b1; end
            OP_NOP:   ;
            OP_ADDI: begin
                if (EN_ADDI) begin
                    dec_ex = 4'b0001;
                    dec_wb = 2'b10;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default:  dec_ill = 1'b1;
        endcase
    end

    // rt == 0 is the zero register, so a load targeting it never creates a dependency
    assign hazard_stall = idex_m[1] && (idex_rt != '0) &&
                          ((idex_rt == id_rs) || (use_rt && (idex_rt == id_rt)));
    // flush and hazard in the same cycle still insert only one bubble
    assign bubble = flush || hazard_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_ex    <= '0;
            idex_m     <= '0;
            idex_wb    <= '0;
            idex_rt    <= '0;
            exmem_m    <= '0;
            exmem_wb   <= '0;
            memwb_wb   <= '0;
            illegal_op <= 1'b0;
            bubble_cnt <= '0;
        end else if (!hold) begin
            memwb_wb   <= exmem_wb;
            exmem_m    <= flush ? 3'b000 : idex_m;
            exmem_wb   <= flush ? 2'b00 : idex_wb;
            idex_ex    <= bubble ? 4'b0000 : dec_ex;
            idex_m     <= bubble ? 3'b000 : dec_m;
            idex_wb    <= bubble ? 2'b00 : dec_wb;
            idex_rt    <= bubble ? '0 : id_rt;
            illegal_op <= !bubble && dec_ill;
            if (bubble && !(&bubble_cnt))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign ex_ctrl  = idex_ex;
    assign mem_ctrl = exmem_m;
    assign wb_ctrl  = memwb_wb;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: scoreboard bench for ctrl_pipe (default, EN_ADDI=1 and CNT_W=2 instances).
module tb_ctrl_pipe;
    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] NOP  = 6'b100000;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = NOP;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;

    logic [3:0]  ex_ctrl, a_ex;
    logic [2:0]  mem_ctrl, a_mem, s_mem;
    logic [1:0]  wb_ctrl, a_wb, s_wb;
    logic        hazard_stall, a_stall, s_stall;
    logic        illegal_op, a_ill, s_ill;
    logic [15:0] bubble_cnt, a_cnt;
    logic [3:0]  s_ex;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    ctrl_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
        .hold(hold), .flush(flush), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
        .wb_ctrl(wb_ctrl), .hazard_stall(hazard_stall), .illegal_op(illegal_op),
        .bubble_cnt(bubble_cnt)
    );

    ctrl_pipe #(.EN_ADDI(1'b1)) u_addi (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
        .hold(hold), .flush(flush), .ex_ctrl(a_ex), .mem_ctrl(a_mem),
        .wb_ctrl(a_wb), .hazard_stall(a_stall), .illegal_op(a_ill),
        .bubble_cnt(a_cnt)
    );

    ctrl_pipe #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
        .hold(hold), .flush(flush), .ex_ctrl(s_ex), .mem_ctrl(s_mem),
        .wb_ctrl(s_wb), .hazard_stall(s_stall), .illegal_op(s_ill),
        .bubble_cnt(s_cnt)
    );

    typedef struct {
        string       nm;
        logic [3:0]  ex;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic        ill;
        logic        stall;
        logic [15:0] cnt;
        logic [3:0]  aex;
        logic [1:0]  awb;
        logic        aill;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, f, act, req);
        end
    endtask

    // Each queued entry describes the outputs visible during the cycle it was issued in.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            cmp(me.nm, "ex_ctrl", 32'(ex_ctrl), 32'(me.ex));
            cmp(me.nm, "mem_ctrl", 32'(mem_ctrl), 32'(me.mem));
            cmp(me.nm, "wb_ctrl", 32'(wb_ctrl), 32'(me.wb));
            cmp(me.nm, "illegal_op", 32'(illegal_op), 32'(me.ill));
            cmp(me.nm, "hazard_stall", 32'(hazard_stall), 32'(me.stall));
            cmp(me.nm, "bubble_cnt", 32'(bubble_cnt), 32'(me.cnt));
            cmp(me.nm, "addi.ex_ctrl", 32'(a_ex), 32'(me.aex));
            cmp(me.nm, "addi.wb_ctrl", 32'(a_wb), 32'(me.awb));
            cmp(me.nm, "addi.illegal_op", 32'(a_ill), 32'(me.aill));
            cmp(me.nm, "sat.bubble_cnt", 32'(s_cnt), (me.cnt > 16'd3) ? 32'd3 : 32'(me.cnt));
        end
    end

    task automatic drv(input logic r, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic h = 1'b0, input logic f = 1'b0);
        @(posedge clk);
        #1;
        rst_n = r; opcode = op; id_rs = rs; id_rt = rt; hold = h; flush = f;
    endtask

    task automatic chk(input string nm, input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                       input logic ill, input logic stall, input int cnt,
                       input int aex = -1, input int awb = -1, input int aill = -1);
        exp_t e;
        e.nm = nm; e.ex = ex; e.mem = mem; e.wb = wb; e.ill = ill; e.stall = stall;
        e.cnt = 16'(cnt);
        e.aex  = (aex  < 0) ? ex  : 4'(aex);
        e.awb  = (awb  < 0) ? wb  : 2'(awb);
        e.aill = (aill < 0) ? ill : 1'(aill);
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        // reset
        drv(0, NOP, 0, 0); chk("reset0", 4'b0000, 3'b000, 2'b00, 0, 0, 0);
        drv(0, NOP, 0, 0); chk("reset1", 4'b0000, 3'b000, 2'b00, 0, 0, 0);
        // back-to-back RTYPE, LW, SW, BEQ, NOP
        drv(1, R,   0, 0); chk("seq1", 4'b0000, 3'b000, 2'b00, 0, 0, 0);
        drv(1, LW,  0, 0); chk("seq2", 4'b1100, 3'b000, 2'b00, 0, 0, 0);
        drv(1, SW,  0, 0); chk("seq3", 4'b0001, 3'b000, 2'b00, 0, 0, 0);
        drv(1, BEQ, 0, 0); chk("seq4", 4'b0001, 3'b010, 2'b10, 0, 0, 0);
        drv(1, NOP, 0, 0); chk("seq5", 4'b0010, 3'b001, 2'b11, 0, 0, 0);
        drv(1, NOP, 0, 0); chk("seq6", 4'b0000, 3'b100, 2'b00, 0, 0, 0);
        drv(1, NOP, 0, 0); chk("seq7", 4'b0000, 3'b000, 2'b00, 0, 0, 0);
        // load-use on rs
        drv(1, LW,  0, 8); chk("lu1", 4'b0000, 3'b000, 2'b00, 0, 0, 0);
        drv(1, R,   8, 0); chk("lu2", 4'b0001, 3'b000, 2'b00, 0, 1, 0);
        drv(1, R,   8, 0); chk("lu3", 4'b0000, 3'b010, 2'b00, 0, 0, 1);
        drv(1, NOP, 0, 0); chk("lu4", 4'b1100, 3'b000, 2'b11, 0, 0, 1);
        // rs=0 with LW rt=0: no stall
        drv(1, LW,  0, 0); chk("z1", 4'b0000, 3'b000, 2'b00, 0, 0, 1);
        drv(1, R,   0, 0); chk("z2", 4'b0001, 3'b000, 2'b10, 0, 0, 1);
        drv(1, NOP, 0, 0); chk("z3", 4'b1100, 3'b010, 2'b00, 0, 0, 1);
        // LW after LW on rt: no stall; SW after LW on rt: stall
        drv(1, LW,  0, 9); chk("rt1", 4'b0000, 3'b000, 2'b11, 0, 0, 1);
        drv(1, LW,  3, 9); chk("rt2", 4'b0001, 3'b000, 2'b10, 0, 0, 1);
        drv(1, SW,  0, 9); chk("rt3", 4'b0001, 3'b010, 2'b00, 0, 1, 1);
        drv(1, SW,  0, 9); chk("rt4", 4'b0000, 3'b010, 2'b11, 0, 0, 2);
        drv(1, NOP, 0, 0); chk("rt5", 4'b0001, 3'b000, 2'b11, 0, 0, 2);
        drv(1, NOP, 0, 0); chk("rt6", 4'b0000, 3'b001, 2'b00, 0, 0, 2);
        drv(1, NOP, 0, 0); chk("rt7", 4'b0000, 3'b000, 2'b00, 0, 0, 2);
        // flush with RTYPE in ID/EX and LW in EX/MEM
        drv(1, LW,  0, 0);          chk("fl1", 4'b0000, 3'b000, 2'b00, 0, 0, 2);
        drv(1, R,   0, 0);          chk("fl2", 4'b0001, 3'b000, 2'b00, 0, 0, 2);
        drv(1, NOP, 0, 0, 0, 1);    chk("fl3", 4'b1100, 3'b010, 2'b00, 0, 0, 2);
        drv(1, NOP, 0, 0);          chk("fl4", 4'b0000, 3'b000, 2'b11, 0, 0, 3);
        // flush coinciding with hazard counts once
        drv(1, LW,  0, 5);          chk("fh1", 4'b0000, 3'b000, 2'b00, 0, 0, 3);
        drv(1, R,   5, 0, 0, 1);    chk("fh2", 4'b0001, 3'b000, 2'b00, 0, 1, 3);
        drv(1, NOP, 0, 0);          chk("fh3", 4'b0000, 3'b000, 2'b00, 0, 0, 4);
        drv(1, NOP, 0, 0);          chk("fh4", 4'b0000, 3'b000, 2'b00, 0, 0, 4);
        // illegal opcodes; ADDI legal only on the EN_ADDI instance
        drv(1, BAD,  0, 0); chk("il1", 4'b0000, 3'b000, 2'b00, 0, 0, 4);
        drv(1, ADDI, 0, 0); chk("il2", 4'b0000, 3'b000, 2'b00, 1, 0, 4);
        drv(1, NOP,  0, 0); chk("il3", 4'b0000, 3'b000, 2'b00, 1, 0, 4, 4'b0001, -1, 0);
        drv(1, NOP,  0, 0); chk("il4", 4'b0000, 3'b000, 2'b00, 0, 0, 4);
        drv(1, NOP,  0, 0); chk("il5", 4'b0000, 3'b000, 2'b00, 0, 0, 4, -1, 2'b10, -1);
        drv(1, NOP,  0, 0); chk("il6", 4'b0000, 3'b000, 2'b00, 0, 0, 4);
        // hold for three edges; a flush during hold is ignored
        drv(1, R,   0, 0);          chk("hd1", 4'b0000, 3'b000, 2'b00, 0, 0, 4);
        drv(1, LW,  0, 0);          chk("hd2", 4'b1100, 3'b000, 2'b00, 0, 0, 4);
        drv(1, SW,  0, 0, 1, 0);    chk("hd3", 4'b0001, 3'b000, 2'b00, 0, 0, 4);
        drv(1, SW,  0, 0, 1, 1);    chk("hd4", 4'b0001, 3'b000, 2'b00, 0, 0, 4);
        drv(1, SW,  0, 0, 1, 0);    chk("hd5", 4'b0001, 3'b000, 2'b00, 0, 0, 4);
        drv(1, SW,  0, 0);          chk("hd6", 4'b0001, 3'b000, 2'b00, 0, 0, 4);
        drv(1, NOP, 0, 0);          chk("hd7", 4'b0001, 3'b010, 2'b10, 0, 0, 4);
        drv(1, NOP, 0, 0);          chk("hd8", 4'b0000, 3'b001, 2'b11, 0, 0, 4);
        drv(1, NOP, 0, 0);          chk("hd9", 4'b0000, 3'b000, 2'b00, 0, 0, 4);
        // mid-stream reset clears everything
        drv(1, LW,  0, 0); chk("rs1", 4'b0000, 3'b000, 2'b00, 0, 0, 4);
        drv(1, R,   0, 0); chk("rs2", 4'b0001, 3'b000, 2'b00, 0, 0, 4);
        drv(0, SW,  0, 0); chk("rs3", 4'b1100, 3'b010, 2'b00, 0, 0, 4);
        drv(1, NOP, 0, 0); chk("rs4", 4'b0000, 3'b000, 2'b00, 0, 0, 0);
        // five bubbles: 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            drv(1, NOP, 0, 0, 0, 1);
            chk($sformatf("sat%0d", i), 4'b0000, 3'b000, 2'b00, 0, 0, i);
        end
        drv(1, NOP, 0, 0); chk("sat5", 4'b0000, 3'b000, 2'b00, 0, 0, 5);
        drv(1, NOP, 0, 0); chk("sat6", 4'b0000, 3'b000, 2'b00, 0, 0, 5);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised, pipelined successor to the single-cycle control decoder. Decodes the ID-stage opcode into EX/M/WB control bundles and carries them through the ID/EX, EX/MEM and MEM/WB registers. Adds load-use hazard detection with bubble insertion, branch flush, external hold, illegal-opcode flagging and a saturating bubble counter. It sits beside the datapath pipeline registers and supplies all stage control.

## Interface
- OPCODE_W, 6, opcode width
- REG_W, 5, register-specifier width
- CNT_W, 16, bubble counter width
- EN_ADDI, 0, 1 = decode ADDI (001000) as a legal opcode

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- opcode  in  OPCODE_W  ID-stage opcode
- id_rs  in  REG_W  ID-stage rs
- id_rt  in  REG_W  ID-stage rt
- hold  in  1  external freeze; all state holds
- flush  in  1  branch taken; squash instructions entering ID/EX and EX/MEM
- ex_ctrl  out  4  ID/EX EX bundle {RegDst, ALUOp[1:0], ALUSrc}
- mem_ctrl  out  3  EX/MEM M bundle {Branch, MemRead, MemWrite}
- wb_ctrl  out  2  MEM/WB WB bundle {RegWrite, MemtoReg}
- hazard_stall  out  1  combinational; datapath holds PC and IF/ID when high
- illegal_op  out  1  registered; high for one cycle when an unknown opcode enters ID/EX
- bubble_cnt  out  CNT_W  bubbles inserted since reset, saturating

## Operation
- Decode (EX/M/WB):
  - RTYPE 000000: 1100/000/10
  - LW 100011: 0001/010/11
  - SW 101011: 0001/001/00
  - BEQ 000100: 0010/100/00
  - NOP 100000: 0000/000/00
  - ADDI 001000 (EN_ADDI=1): 0001/000/10
- Don't-cares resolve to 0; outputs are never X or Z.
- Unknown opcodes, including ADDI when EN_ADDI=0, decode to all-zero bundles and set illegal_op.
- Internal state:
  - ID/EX: {EX, M, WB, rt}
  - EX/MEM: {M, WB}
  - MEM/WB: {WB}
- Load-use hazard: hazard_stall = idex.MemRead & idex_rt != 0 & (idex_rt == id_rs | (use_rt & idex_rt == id_rt)).
  - use_rt is 1 for RTYPE, SW and BEQ; 0 otherwise.
  - id_rs == 0 never matches, because idex_rt must be nonzero.
- Per-edge priority: rst_n low > hold > flush > hazard > normal.
  - Reset: every stage register, illegal_op and bubble_cnt go to 0.
  - Hold: all registers keep their value. illegal_op keeps its value. bubble_cnt is unchanged.
  - Flush: ID/EX and EX/MEM load zero. MEM/WB loads EX/MEM normally. bubble_cnt += 1. illegal_op is 0.
  - Hazard: ID/EX loads zero (bubble). EX/MEM and MEM/WB advance. bubble_cnt += 1. illegal_op is 0. The datapath re-presents the same opcode next cycle.
  - Normal: ID/EX loads the decode; EX/MEM <- ID/EX; MEM/WB <- EX/MEM.
- bubble_cnt saturates at 2^CNT_W-1 and does not wrap.
- Only one increment happens per cycle; flush and hazard together count once.

## Timing
- The opcode presented in cycle n appears on:
  - ex_ctrl in n+1
  - mem_ctrl in n+2
  - wb_ctrl in n+3
- illegal_op is aligned with ex_ctrl of the offending instruction, i.e. it is high in cycle n+1.
- hazard_stall has zero latency, derived from the current ID/EX contents and ID inputs.
- A LW followed directly by a dependent instruction gives exactly one bubble. After that bubble ID/EX.MemRead=0, so the next cycle proceeds.
- The reset value of every output is 0. hazard_stall is 0 during and after reset, because ID/EX is zero.
- Reset asserted mid-stream clears the pipe on that edge; nothing in flight survives.
- Hold deasserting resumes from the frozen state without losing or duplicating instructions.

## Test plan
- Present RTYPE, LW, SW, BEQ, NOP on consecutive cycles with no hazards:
  - ex_ctrl = 1100, 0001, 0001, 0010, 0000 in cycles 1-5.
  - mem_ctrl lags by one cycle; wb_ctrl = 10, 11, 00, 00, 00 in cycles 3-7.
- LW with rt=8, then RTYPE with rs=8:
  - hazard_stall=1 for one cycle; ex_ctrl=0000 bubble; bubble_cnt=1.
  - The RTYPE then issues and ex_ctrl=1100.
  - Repeat with id_rs=0 and rt=0 in LW: no stall.
- LW with rt=9, then LW with rs=3 and rt=9: no stall, since use_rt=0.
  - SW with rt=9 after LW with rt=9: one-cycle stall.
- Assert flush with RTYPE in ID/EX and LW in EX/MEM:
  - Next cycle ex_ctrl=0000 and mem_ctrl=000; wb_ctrl shows the prior EX/MEM WB.
  - bubble_cnt increments once, including when flush coincides with hazard.
- Opcode 111111, and 001000 with EN_ADDI=0:
  - illegal_op pulses for one cycle; all bundles are 0.
  - With EN_ADDI=1, 001000 gives ex_ctrl=0001, wb_ctrl=10 and no illegal_op.
- Boundary and reset checks:
  - hold for 3 cycles mid-stream: outputs frozen, then the sequence resumes intact.
  - CNT_W=2: force 5 bubbles; bubble_cnt=3.
  - rst_n low mid-stream for one edge: all outputs 0 next cycle.
